// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus ACK levels, default target address and target FSM states.
package i2c_pkg;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam logic [6:0] I2C_DEFAULT_ADDR  = 7'b0110100;
  localparam logic [7:0] I2C_UNDERRUN_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrData,
    StWrAck,
    StRdData,
    StRdAck,
    StIgnore
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer and glitch filter for one I2C line, with edge strobes
// aligned to the filtered level.
module i2c_line_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_LEN - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_d;

  // The filtered level flips only after FILTER_LEN consecutive differing samples.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = level_q & ~prev_q;
  assign fall  = ~level_q & prev_q;

endmodule

// File: rtl/i2c_target_port.sv
// I2C target: matches a 7-bit address, ACKs and delivers write bytes to the fabric and
// shifts out fabric-supplied bytes on reads. Never stretches SCL.
module i2c_target_port
  import i2c_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = I2C_DEFAULT_ADDR,
  parameter int unsigned FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       stop_pulse
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_scl_filter (
    .clk  (clk),
    .rst  (rst),
    .line (scl_i),
    .level(scl_lvl),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  i2c_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_sda_filter (
    .clk  (clk),
    .rst  (rst),
    .line (sda_i),
    .level(sda_lvl),
    .rise (sda_rise),
    .fall (sda_fall)
  );

  logic start_det, stop_det;
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  i2c_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       phase_q, phase_d;
  logic       rw_q, rw_d;
  logic       first_q, first_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_first_q, rx_first_d;
  logic       busy_q, busy_d;
  logic       stop_pulse_q, stop_pulse_d;
  logic       load_en;
  logic [7:0] tx_byte;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    phase_d      = phase_q;
    rw_d         = rw_q;
    first_d      = first_q;
    sda_oe_d     = sda_oe_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    rx_first_d   = rx_first_q;
    busy_d       = busy_q;
    stop_pulse_d = 1'b0;
    load_en      = 1'b0;
    tx_byte      = tx_valid ? tx_data : I2C_UNDERRUN_BYTE;

    // Bus conditions take priority over any bit or ACK action in the same cycle.
    if (start_det) begin
      state_d   = StAddr;
      bit_cnt_d = '0;
      phase_d   = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (stop_det) begin
      state_d      = StIdle;
      sda_oe_d     = 1'b0;
      busy_d       = 1'b0;
      stop_pulse_d = busy_q;
    end else begin
      case (state_q)
        StAddr, StWrData: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              phase_d = 1'b0;
              if (state_q == StAddr) begin
                rw_d = sda_lvl;
                if (shift_q[6:0] == TARGET_ADDR) begin
                  state_d = StAddrAck;
                  busy_d  = 1'b1;
                  first_d = 1'b1;
                end else begin
                  state_d = StIgnore;
                end
              end else begin
                rx_data_d  = {shift_q[6:0], sda_lvl};
                rx_valid_d = 1'b1;
                rx_first_d = first_q;
                first_d    = 1'b0;
                state_d    = StWrAck;
              end
            end
          end
        end
        // First SCL fall pulls SDA for the ACK slot, the second ends it.
        StAddrAck, StWrAck: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              phase_d   = 1'b0;
              bit_cnt_d = '0;
              if (state_q == StAddrAck && rw_q) begin
                load_en = 1'b1;
              end else begin
                state_d = StWrData;
              end
            end
          end
        end
        StRdData: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              state_d  = StRdAck;
            end else begin
              sda_oe_d  = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b1};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        // phase_q marks an ACK seen; the next byte loads on the following fall.
        StRdAck: begin
          if (scl_rise && !phase_q) begin
            if (sda_lvl == I2C_NACK) begin
              busy_d  = 1'b0;
              state_d = StIgnore;
            end else begin
              phase_d = 1'b1;
            end
          end else if (scl_fall && phase_q) begin
            load_en = 1'b1;
          end
        end
        default: ;
      endcase

      if (load_en) begin
        sda_oe_d  = ~tx_byte[7];
        shift_d   = {tx_byte[6:0], 1'b1};
        bit_cnt_d = 4'd1;
        phase_d   = 1'b0;
        state_d   = StRdData;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      phase_q      <= 1'b0;
      rw_q         <= 1'b0;
      first_q      <= 1'b0;
      sda_oe_q     <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_first_q   <= 1'b0;
      busy_q       <= 1'b0;
      stop_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      phase_q      <= phase_d;
      rw_q         <= rw_d;
      first_q      <= first_d;
      sda_oe_q     <= sda_oe_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_first_q   <= rx_first_d;
      busy_q       <= busy_d;
      stop_pulse_q <= stop_pulse_d;
    end
  end

  assign sda_oe     = sda_oe_q;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_first   = rx_first_q;
  assign tx_ready   = load_en & tx_valid;
  assign busy       = busy_q;
  assign stop_pulse = stop_pulse_q;

endmodule

// File: tb/tb_i2c_target_port.sv
// Bench for i2c_target_port: a bit-banged I2C master on an open-drain bus, with
// transaction-level expectations derived from the address and the fabric byte rules.
module tb_i2c_target_port;

  localparam int unsigned Q = 10;
  localparam int unsigned H = 20;
  localparam logic [6:0] TgtAddr = 7'h34;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda_low = 1'b0;
  logic       scl_i, sda_i;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid, rx_first;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, stop_pulse;

  assign scl_i = m_scl;
  assign sda_i = ~(m_sda_low | sda_oe);

  always #5 clk = ~clk;

  i2c_target_port #(
    .TARGET_ADDR(TgtAddr),
    .FILTER_LEN (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_oe    (sda_oe),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_first  (rx_first),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .stop_pulse(stop_pulse)
  );

  // Event monitor: the stimulus reads these logs but never writes them.
  logic [8:0] rx_log[$];
  int tx_n = 0, stop_n = 0, oe_n = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) rx_log.push_back({rx_first, rx_data});
      if (tx_ready) tx_n <= tx_n + 1;
      if (stop_pulse) stop_n <= stop_n + 1;
      if (sda_oe) oe_n <= oe_n + 1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b1;
    cyc(H);
    m_scl = 1'b0;
    cyc(Q);
  endtask

  task automatic bus_rstart();
    m_sda_low = 1'b0;
    cyc(Q);
    m_scl = 1'b1;
    cyc(H);
    m_sda_low = 1'b1;
    cyc(H);
    m_scl = 1'b0;
    cyc(Q);
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1;
    cyc(Q);
    m_scl = 1'b1;
    cyc(H);
    m_sda_low = 1'b0;
    cyc(H);
  endtask

  // Entered and left with SCL low; samples the bus mid-way through SCL high.
  task automatic bus_bit(input logic b, output logic s);
    m_sda_low = ~b;
    cyc(Q);
    m_scl = 1'b1;
    cyc(Q);
    s = sda_i;
    cyc(Q);
    m_scl = 1'b0;
    cyc(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic [7:0] b;
    logic s;
    b = d;
    for (int i = 0; i < 8; i++) begin
      bus_bit(b[7], s);
      b = b << 1;
    end
    bus_bit(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bus_bit(1'b1, s);
      d = {d[6:0], s};
    end
  endtask

  task automatic do_write(input logic [6:0] addr, input int n, input logic [7:0] dat[4]);
    logic ack;
    logic match;
    int rx0, st0, oe0;
    match = (addr == TgtAddr);
    rx0 = rx_log.size();
    st0 = stop_n;
    oe0 = oe_n;
    bus_start();
    write_byte({addr, 1'b0}, ack);
    check_val("wr_addr_ack", 32'(ack), match ? 32'd0 : 32'd1);
    for (int i = 0; i < n; i++) begin
      write_byte(dat[i], ack);
      check_val("wr_data_ack", 32'(ack), match ? 32'd0 : 32'd1);
    end
    check_val("wr_busy", 32'(busy), 32'(match));
    bus_stop();
    cyc(10);
    check_val("wr_rx_count", 32'(rx_log.size() - rx0), match ? 32'(n) : 32'd0);
    if (match && rx_log.size() == rx0 + n) begin
      for (int i = 0; i < n; i++)
        check_val("wr_rx_byte", 32'(rx_log[rx0 + i]), 32'({i == 0, dat[i]}));
    end
    check_val("wr_stop_pulse", 32'(stop_n - st0), 32'(match));
    check_val("wr_busy_after", 32'(busy), 32'd0);
    if (!match) check_val("wr_nomatch_oe", 32'(oe_n - oe0), 32'd0);
  endtask

  task automatic do_read(input logic [6:0] addr, input int n, input logic tv[4],
                         input logic [7:0] td[4]);
    logic ack, s;
    logic match;
    logic [7:0] got;
    int tx0, st0, nvalid;
    match = (addr == TgtAddr);
    tx0 = tx_n;
    st0 = stop_n;
    nvalid = 0;
    tx_valid = tv[0];
    tx_data = td[0];
    bus_start();
    write_byte({addr, 1'b1}, ack);
    check_val("rd_addr_ack", 32'(ack), match ? 32'd0 : 32'd1);
    for (int i = 0; i < n; i++) begin
      read_byte(got);
      check_val("rd_byte", 32'(got), (match && tv[i]) ? 32'(td[i]) : 32'hFF);
      if (tv[i]) nvalid++;
      if (i < n - 1) begin
        tx_valid = tv[i + 1];
        tx_data = td[i + 1];
      end
      bus_bit(i == n - 1, s);
    end
    cyc(2);
    check_val("rd_busy_nack", 32'(busy), 32'd0);
    check_val("rd_sda_released", 32'(sda_oe), 32'd0);
    check_val("rd_tx_ready", 32'(tx_n - tx0), match ? 32'(nvalid) : 32'd0);
    tx_valid = 1'b0;
    bus_stop();
    cyc(10);
    check_val("rd_stop_pulse", 32'(stop_n - st0), 32'd0);
  endtask

  initial begin
    logic [7:0] dat[4];
    logic       tv[4];
    logic       ack, s;
    logic [6:0] addr;
    int         oe0, st0, rx0;

    cyc(5);
    @(posedge clk);
    #1;
    check_val("rst_sda_oe", 32'(sda_oe), 32'd0);
    check_val("rst_rx_data", 32'(rx_data), 32'd0);
    check_val("rst_outs", 32'({rx_valid, rx_first, tx_ready, busy, stop_pulse}), 32'd0);
    cyc(1);
    rst = 1'b0;
    cyc(20);

    dat = '{8'hAA, 8'h00, 8'h00, 8'h00};
    do_write(7'h34, 1, dat);
    do_write(7'h35, 1, dat);

    tv = '{1'b1, 1'b0, 1'b0, 1'b0};
    dat = '{8'h5C, 8'h00, 8'h00, 8'h00};
    do_read(7'h34, 1, tv, dat);
    tv = '{1'b0, 1'b1, 1'b0, 1'b0};
    dat = '{8'h77, 8'h12, 8'h00, 8'h00};
    do_read(7'h34, 2, tv, dat);

    // Repeated START cuts a write byte short after 4 bits.
    rx0 = rx_log.size();
    st0 = stop_n;
    bus_start();
    write_byte({TgtAddr, 1'b0}, ack);
    check_val("rs_addr1_ack", 32'(ack), 32'd0);
    bus_bit(1'b1, s);
    bus_bit(1'b0, s);
    bus_bit(1'b1, s);
    bus_bit(1'b1, s);
    bus_rstart();
    write_byte({TgtAddr, 1'b0}, ack);
    check_val("rs_addr2_ack", 32'(ack), 32'd0);
    write_byte(8'h01, ack);
    check_val("rs_data_ack", 32'(ack), 32'd0);
    bus_stop();
    cyc(10);
    check_val("rs_rx_count", 32'(rx_log.size() - rx0), 32'd1);
    if (rx_log.size() > rx0) check_val("rs_rx_byte", 32'(rx_log[rx0]), 32'h101);
    check_val("rs_stop_pulse", 32'(stop_n - st0), 32'd1);

    // Reset while the target is pulling SDA for a 0x00 read byte.
    tx_valid = 1'b1;
    tx_data = 8'h00;
    bus_start();
    write_byte({TgtAddr, 1'b1}, ack);
    check_val("mr_addr_ack", 32'(ack), 32'd0);
    for (int k = 0; k < 50 && !sda_oe; k++) cyc(1);
    check_val("mr_oe_before", 32'(sda_oe), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("mr_sda_oe", 32'(sda_oe), 32'd0);
    check_val("mr_rx_data", 32'(rx_data), 32'd0);
    check_val("mr_outs", 32'({rx_valid, rx_first, tx_ready, busy, stop_pulse}), 32'd0);
    tx_valid = 1'b0;
    m_scl = 1'b1;
    m_sda_low = 1'b0;
    cyc(10);
    rst = 1'b0;
    cyc(20);

    // Short glitches in IDLE must not register as clocks or as a START.
    oe0 = oe_n;
    st0 = stop_n;
    m_scl = 1'b0;
    cyc(1);
    m_scl = 1'b1;
    cyc(20);
    check_val("gl_scl_busy", 32'(busy), 32'd0);
    m_sda_low = 1'b1;
    cyc(2);
    m_sda_low = 1'b0;
    cyc(20);
    m_scl = 1'b0;
    cyc(Q);
    write_byte({TgtAddr, 1'b0}, ack);
    check_val("gl_no_start_ack", 32'(ack), 32'd1);
    check_val("gl_oe", 32'(oe_n - oe0), 32'd0);
    bus_stop();
    cyc(10);
    check_val("gl_stop_pulse", 32'(stop_n - st0), 32'd0);

    for (int t = 0; t < 10; t++) begin
      int n;
      addr = TgtAddr;
      if ($urandom_range(0, 3) == 0) begin
        addr = 7'($urandom_range(0, 127));
        if (addr == TgtAddr) addr = 7'h35;
      end
      n = int'($urandom_range(1, 3));
      for (int i = 0; i < 4; i++) begin
        dat[i] = 8'($urandom_range(0, 255));
        tv[i] = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 1) == 0) do_write(addr, n, dat);
      else do_read(addr, n, tv, dat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
